fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL declare the parameter DEPTH, default 4: number of queue entries, a power of two and at least 2.
REQ-002 SHALL declare the parameter AFULL, default DEPTH-1: occupancy at which stall_o asserts.
REQ-003 SHALL have clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have v_i  input  1  fetched word valid, driven by the fetch stage valid.
REQ-006 SHALL have pc_i  input  `ADDR  address of the fetched word.
REQ-007 SHALL have inst_i  input  `INST  fetched instruction word.
REQ-008 SHALL have flush_i  input  1  branch taken, the same signal the fetch stage receives as branch.
REQ-009 SHALL have stall_o  output  1  backpressure to the fetch stage stall input.
REQ-010 SHALL have v_o  output  1  head entry valid toward decode.
REQ-011 SHALL have pc_o  output  `ADDR  head entry address.
REQ-012 SHALL have inst_o  output  `INST  head entry instruction.
REQ-013 SHALL have ready_i  input  1  decode accepts the head entry this cycle.
REQ-014 SHALL have count_o  output  clog2(DEPTH)+1  current occupancy.
REQ-015 SHALL have ovf_o  output  1  sticky overflow error flag.

Function
REQ-016 SHALL operate as a circular FIFO with write pointer, read pointer and occupancy counter, each pointer wrapping modulo DEPTH.
REQ-017 SHALL define push = v_i && ~flush_i && (count<DEPTH || pop).
REQ-018 SHALL define pop = v_o && ready_i.
REQ-019 SHALL make a word pushed in cycle N visible at v_o no earlier than cycle N+1, with no write-to-read bypass.
REQ-020 SHALL drive v_o = (count!=0) && ~flush_i, and drive pc_o/inst_o from the entry at the read pointer.
REQ-021 SHALL drive stall_o = (count >= AFULL), decoded combinationally from registered count only, so one slot of headroom absorbs the word already in flight when the fetch stage sees the stall.
REQ-022 SHALL update count as count+1 on push only, count-1 on pop only, and leave it unchanged on both or neither.
REQ-023 SHALL accept a push to a full queue when a pop occurs in the same cycle, with count staying at DEPTH.
REQ-024 SHALL, when v_i arrives with count==DEPTH, no pop and no flush, drop the word, leave the pointers unchanged, and set ovf_o=1 from the next cycle.
REQ-025 SHALL, on flush_i=1, reset both pointers and count to 0 at the next edge, discard any same-cycle v_i, hold v_o=0 in the flush cycle, and perform no pop.
REQ-026 SHALL let flush_i take priority over push, pop and overflow detection.
REQ-027 SHALL, with an empty queue and ready_i=1, hold v_o low and perform no pop.
REQ-028 SHALL hold pc_o/inst_o stable while v_o=1 and ready_i=0.

Reset
REQ-029 SHALL, while rst=1, clear pointers, count_o=0, ovf_o=0, v_o=0 and stall_o=0 at the next rising edge.
REQ-030 SHALL not reset storage contents; pc_o/inst_o are don't-care while v_o=0.
REQ-031 SHALL give rst priority over flush_i, push and pop, and discard a push presented during reset.
REQ-032 SHALL clear ovf_o only by rst.

Structure
REQ-033 SHALL take `ADDR and `INST from include/params.vh and add `IFQ_DEPTH there as the default for DEPTH.
REQ-034 SHALL be a single module with no sub-module; storage is a register array inside fetch_queue.

Verification
REQ-035 SHALL cover fill: DEPTH=4, ready_i=0, push pc 0,1,2 -> stall_o=1 after the third edge; the fourth in-flight word (pc 3) is accepted, count_o=4, ovf_o=0.
REQ-036 SHALL cover overflow: full queue, ready_i=0, v_i=1 with pc 4 -> word dropped, ovf_o=1 next cycle, count_o stays 4.
REQ-037 SHALL cover full push+pop: full queue, ready_i=1, v_i=1 pc 4 -> pc_o=0 consumed, count_o stays 4, later pops return 1,2,3,4 in order.
REQ-038 SHALL cover flush: 3 entries, flush_i=1 with v_i=1 -> v_o=0 that cycle, count_o=0 next cycle, the pushed word never appears at v_o.
REQ-039 SHALL cover wrap-around: 10 streamed words pc 0..9 with ready_i=1 every cycle -> v_o outputs 0..9 in order, one cycle after each push, pointers wrapping without loss.
REQ-040 SHALL cover reset mid-operation: rst=1 with 2 entries and ovf_o=1 -> next cycle count_o=0, ovf_o=0, v_o=0, stall_o=0.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared widths, default depth and entry layout for the fetch queue.
package fetch_queue_pkg;

  localparam int ADDR_W    = 32;
  localparam int INST_W    = 32;
  localparam int IFQ_DEPTH = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch-to-decode buffer with early stall, sticky overflow flag and
// flush-on-branch; storage lives in a plain register array.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int AFULL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       v_i,
  input  logic [ADDR_W-1:0]          pc_i,
  input  logic [INST_W-1:0]          inst_i,
  input  logic                       flush_i,
  output logic                       stall_o,
  output logic                       v_o,
  output logic [ADDR_W-1:0]          pc_o,
  output logic [INST_W-1:0]          inst_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       ovf_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fq_entry_t       mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic            ovf;
  logic            full;
  logic            push;
  logic            pop;
  logic            drop;

  // A full queue still takes a word when the head leaves in the same cycle.
  assign full    = (count == CW'(DEPTH));
  assign v_o     = (count != '0) && !flush_i;
  assign pop     = v_o && ready_i;
  assign push    = v_i && !flush_i && (!full || pop);
  assign drop    = v_i && !flush_i && full && !pop;
  assign stall_o = (count >= CW'(AFULL));
  assign pc_o    = mem[rptr].pc;
  assign inst_o  = mem[rptr].inst;
  assign count_o = count;
  assign ovf_o   = ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (flush_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) ovf <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset; contents only matter while v_o is high.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wptr] <= '{pc: pc_i, inst: inst_i};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// queue-based model of the fetch buffer.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int AFULL = DEPTH - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              v_i = 1'b0;
  logic [ADDR_W-1:0] pc_i = '0;
  logic [INST_W-1:0] inst_i = '0;
  logic              flush_i = 1'b0;
  logic              ready_i = 1'b0;
  logic              stall_o;
  logic              v_o;
  logic [ADDR_W-1:0] pc_o;
  logic [INST_W-1:0] inst_o;
  logic [$clog2(DEPTH):0] count_o;
  logic              ovf_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;

  fq_entry_t mq[$];
  bit        m_ovf;
  bit        exp_v;
  bit        m_pop;
  bit        m_push;
  bit        m_full;

  fetch_queue #(.DEPTH(DEPTH), .AFULL(AFULL)) dut (
    .clk(clk), .rst(rst), .v_i(v_i), .pc_i(pc_i), .inst_i(inst_i),
    .flush_i(flush_i), .stall_o(stall_o), .v_o(v_o), .pc_o(pc_o),
    .inst_o(inst_o), .ready_i(ready_i), .count_o(count_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change one unit after the falling edge and hold through the next rising edge.
  task automatic applyStimulus(input logic rs, input logic v, input logic fl,
                               input logic rd, input logic [ADDR_W-1:0] pc);
    @(negedge clk);
    #1;
    rst     = rs;
    v_i     = v;
    flush_i = fl;
    ready_i = rd;
    pc_i    = pc;
    inst_i  = {pc[15:0], ~pc[15:0]};
  endtask

  // Per-cycle comparison against the model, then advance the model by one edge.
  always @(negedge clk) begin
    #3;
    exp_v = (mq.size() != 0) && !flush_i;
    if (check_en) begin
      checkOutput("count_o", 64'(count_o), 64'(mq.size()));
      checkOutput("stall_o", 64'(stall_o), 64'(mq.size() >= AFULL));
      checkOutput("v_o",     64'(v_o),     64'(exp_v));
      checkOutput("ovf_o",   64'(ovf_o),   64'(m_ovf));
      if (exp_v) begin
        checkOutput("pc_o",   64'(pc_o),   64'(mq[0].pc));
        checkOutput("inst_o", 64'(inst_o), 64'(mq[0].inst));
      end
    end
    if (rst) begin
      mq.delete();
      m_ovf = 0;
    end else if (flush_i) begin
      mq.delete();
    end else begin
      m_pop  = exp_v && ready_i;
      m_full = (mq.size() == DEPTH);
      m_push = v_i && (!m_full || m_pop);
      if (v_i && m_full && !m_pop) m_ovf = 1;
      if (m_pop)  void'(mq.pop_front());
      if (m_push) mq.push_back('{pc: pc_i, inst: inst_i});
    end
  end

  initial begin
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    check_en = 1;
    #1;
    checkOutput("rst_count", 64'(count_o), 0);
    checkOutput("rst_v",     64'(v_o),     0);
    checkOutput("rst_stall", 64'(stall_o), 0);
    checkOutput("rst_ovf",   64'(ovf_o),   0);

    // Fill with decode stalled; stall rises once three words are held.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 0, ADDR_W'(i));
      #1;
      checkOutput("fill_count", 64'(count_o), 64'(i));
      checkOutput("fill_stall", 64'(stall_o), 64'(i >= 3));
    end

    // Overflow attempt into a full queue.
    applyStimulus(0, 1, 0, 0, 4);
    #1;
    checkOutput("full_count", 64'(count_o), 4);
    checkOutput("full_ovf",   64'(ovf_o),   0);

    // Push and pop together on a full queue.
    applyStimulus(0, 1, 0, 1, 4);
    #1;
    checkOutput("ovf_set",   64'(ovf_o),   1);
    checkOutput("pp_count",  64'(count_o), 4);
    checkOutput("pp_head",   64'(pc_o),    0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(0, 0, 0, 1, 0);
      #1;
      checkOutput("drain_pc",    64'(pc_o),    64'(k));
      checkOutput("drain_count", 64'(count_o), 64'(5 - k));
    end

    // Flush with three entries and a word arriving in the same cycle.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, ADDR_W'(10 + i));
    applyStimulus(0, 1, 1, 0, 13);
    #1;
    checkOutput("flush_v",     64'(v_o),     0);
    checkOutput("flush_count", 64'(count_o), 3);
    applyStimulus(0, 0, 0, 1, 0);
    #1;
    checkOutput("post_flush_count", 64'(count_o), 0);
    checkOutput("post_flush_v",     64'(v_o),     0);

    // Streaming through the wrap point, one cycle of latency per word.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 0, 1, ADDR_W'(20 + i));
      #1;
      if (i > 0) checkOutput("wrap_pc", 64'(pc_o), 64'(20 + i - 1));
      checkOutput("wrap_v", 64'(v_o), 64'(i > 0));
    end
    applyStimulus(0, 0, 0, 1, 0);
    #1;
    checkOutput("wrap_last", 64'(pc_o), 29);

    // Reset while holding entries and a set overflow flag.
    applyStimulus(0, 1, 0, 0, 30);
    applyStimulus(0, 1, 0, 0, 31);
    applyStimulus(1, 1, 0, 0, 32);
    #1;
    checkOutput("pre_rst_ovf",   64'(ovf_o),   1);
    checkOutput("pre_rst_count", 64'(count_o), 2);
    applyStimulus(0, 0, 0, 0, 0);
    #1;
    checkOutput("mid_rst_count", 64'(count_o), 0);
    checkOutput("mid_rst_ovf",   64'(ovf_o),   0);
    checkOutput("mid_rst_v",     64'(v_o),     0);
    checkOutput("mid_rst_stall", 64'(stall_o), 0);

    // Randomized traffic; the model compare covers every cycle.
    for (int n = 0; n < 2000; n++) begin
      applyStimulus($urandom_range(199) == 0,
                    $urandom_range(3) != 0,
                    $urandom_range(15) == 0,
                    $urandom_range(1) == 1,
                    ADDR_W'($urandom));
    end
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    #5;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
